// File: rtl/phy_link_pkg.sv
// Shared types and constants for the PHY transmit link controller.
package phy_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    ACTIVE = 2'd2
  } link_state_t;

  localparam logic [31:0] IDLE_WORD_DFLT = 32'hBCBCBCBC;

endpackage

// File: rtl/phy_link_ctrl_if.sv
// Requester handshake bundle: two sources offering words to the link controller.
interface phy_link_ctrl_if #(
  parameter int DATA_W = 32
);
  logic              req_valid_0;
  logic              req_valid_1;
  logic [DATA_W-1:0] req_data_0;
  logic [DATA_W-1:0] req_data_1;
  logic              req_ready_0;
  logic              req_ready_1;

  modport master (
    output req_valid_0, req_valid_1, req_data_0, req_data_1,
    input  req_ready_0, req_ready_1
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_data_0, req_data_1,
    output req_ready_0, req_ready_1
  );
endinterface

// File: rtl/phy_rr_arbiter.sv
// Two-way round-robin arbiter with a burst limit; grant is combinational,
// owner/pointer/burst count update on accepted words.
module phy_rr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req_valid,
  output logic [1:0] gnt
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic [1:0]       owner;
  logic             ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic             keep;

  always_comb begin
    gnt  = 2'b00;
    keep = (|(owner & req_valid)) && (burst_cnt < BURST_MAX);
    if (en) begin
      if (keep)                gnt      = owner;
      else if (req_valid[ptr])  gnt[ptr]  = 1'b1;
      else if (req_valid[~ptr]) gnt[~ptr] = 1'b1;
    end
  end

  // A same-owner grant at the limit only happens when the other side is idle,
  // so the burst count restarts instead of saturating.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      owner     <= 2'b00;
      ptr       <= 1'b0;
      burst_cnt <= '0;
    end else if (|gnt) begin
      owner <= gnt;
      ptr   <= gnt[0];
      if ((gnt == owner) && (burst_cnt < BURST_MAX)) burst_cnt <= burst_cnt + CNT_W'(1);
      else                                          burst_cnt <= CNT_W'(1);
    end else begin
      owner     <= 2'b00;
      burst_cnt <= '0;
    end
  end
endmodule

// File: rtl/phy_link_ctrl.sv
// Transmit link controller: IDLE/TRAIN/ACTIVE bring-up FSM, registered PHY drive,
// and round-robin sharing of the PHY input between two requesters.
module phy_link_ctrl
  import phy_link_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                TRAIN_WORDS = 4,
  parameter int                MAX_BURST   = 4,
  parameter logic [DATA_W-1:0] IDLE_WORD   = DATA_W'(IDLE_WORD_DFLT)
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic              link_en,
  phy_link_ctrl_if.slave    req,
  output logic              phy_active,
  output logic              phy_valid,
  output logic [DATA_W-1:0] phy_data,
  output logic              link_up,
  output logic [1:0]        grant
);
  localparam int CNT_W = $clog2(TRAIN_WORDS + 1);
  localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_WORDS - 1);

  link_state_t       state, state_nxt;
  logic [CNT_W-1:0]  train_cnt, train_cnt_nxt;
  logic              arb_en;
  logic [1:0]        gnt;
  logic              active_nxt, valid_nxt, link_up_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [1:0]        grant_nxt;

  // Dropping link_en blocks acceptance in the same cycle.
  assign arb_en = (state == ACTIVE) && link_en;

  phy_rr_arbiter #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .en        (arb_en),
    .req_valid ({req.req_valid_1, req.req_valid_0}),
    .gnt       (gnt)
  );

  assign req.req_ready_0 = gnt[0];
  assign req.req_ready_1 = gnt[1];

  always_comb begin
    state_nxt     = state;
    train_cnt_nxt = train_cnt;
    active_nxt    = 1'b0;
    valid_nxt     = 1'b0;
    link_up_nxt   = 1'b0;
    data_nxt      = '0;
    grant_nxt     = 2'b00;
    unique case (state)
      IDLE: begin
        train_cnt_nxt = '0;
        if (link_en) state_nxt = TRAIN;
      end
      TRAIN: begin
        if (!link_en) begin
          state_nxt     = IDLE;
          train_cnt_nxt = '0;
        end else begin
          active_nxt = 1'b1;
          data_nxt   = IDLE_WORD;
          if (train_cnt == TRAIN_LAST) begin
            state_nxt     = ACTIVE;
            train_cnt_nxt = '0;
          end else begin
            train_cnt_nxt = train_cnt + CNT_W'(1);
          end
        end
      end
      ACTIVE: begin
        if (!link_en) begin
          state_nxt = IDLE;
        end else begin
          active_nxt  = 1'b1;
          link_up_nxt = 1'b1;
          if (|gnt) begin
            valid_nxt = 1'b1;
            data_nxt  = gnt[1] ? req.req_data_1 : req.req_data_0;
            grant_nxt = gnt;
          end else begin
            data_nxt = IDLE_WORD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      train_cnt  <= '0;
      phy_active <= 1'b0;
      phy_valid  <= 1'b0;
      phy_data   <= '0;
      link_up    <= 1'b0;
      grant      <= 2'b00;
    end else begin
      state      <= state_nxt;
      train_cnt  <= train_cnt_nxt;
      phy_active <= active_nxt;
      phy_valid  <= valid_nxt;
      phy_data   <= data_nxt;
      link_up    <= link_up_nxt;
      grant      <= grant_nxt;
    end
  end
endmodule

// File: tb/tb_phy_link_ctrl.sv
// Bench for phy_link_ctrl: training vector table, scoreboarded request streams,
// and hand sequences for link drop and asynchronous reset.
module tb_phy_link_ctrl;
  localparam logic [31:0] IDLE_W = 32'hBCBCBCBC;

  logic        clk_2f = 1'b0;
  logic        reset;
  logic        link_en;
  logic        phy_active, phy_valid, link_up;
  logic [31:0] phy_data;
  logic [1:0]  grant;

  int n_tests = 0;
  int n_fail  = 0;

  phy_link_ctrl_if #(.DATA_W(32)) bus ();

  phy_link_ctrl #(.DATA_W(32), .TRAIN_WORDS(4), .MAX_BURST(4)) dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .link_en    (link_en),
    .req        (bus),
    .phy_active (phy_active),
    .phy_valid  (phy_valid),
    .phy_data   (phy_data),
    .link_up    (link_up),
    .grant      (grant)
  );

  always #5 clk_2f = ~clk_2f;

  typedef struct {
    logic        link_en;
    logic        v0;
    logic        exp_ready;
    logic        exp_active;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_link_up;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] src0_q[$];
  logic [31:0] src1_q[$];
  logic [33:0] exp_q[$];
  logic [1:0]  gnt_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_vec(input logic le, input logic v0, input logic rdy, input logic act,
                         input logic vld, input logic [31:0] dat, input logic lu);
    vec_t v;
    v.link_en = le; v.v0 = v0; v.exp_ready = rdy; v.exp_active = act;
    v.exp_valid = vld; v.exp_data = dat; v.exp_link_up = lu;
    tv.push_back(v);
  endtask

  task automatic step();
    @(posedge clk_2f);
    #1;
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_active"}, phy_active, 1'b0);
    check({tag, "_valid"}, phy_valid, 1'b0);
    check({tag, "_data"}, phy_data, 32'h0);
    check({tag, "_link_up"}, link_up, 1'b0);
    check({tag, "_grant"}, grant, 2'b00);
  endtask

  // Drive queued source words for ncyc cycles; accepted words go to the scoreboard
  // and must appear on the PHY exactly one edge later.
  task automatic run(input int ncyc);
    logic        acc;
    logic [33:0] e;
    for (int c = 0; c < ncyc; c++) begin
      bus.req_valid_0 = (src0_q.size() != 0);
      bus.req_data_0  = (src0_q.size() != 0) ? src0_q[0] : 32'h0;
      bus.req_valid_1 = (src1_q.size() != 0);
      bus.req_data_1  = (src1_q.size() != 0) ? src1_q[0] : 32'h0;
      #2;
      check("one_ready", bus.req_ready_0 & bus.req_ready_1, 1'b0);
      acc = 1'b0;
      if (bus.req_valid_0 && bus.req_ready_0) begin
        exp_q.push_back({2'b01, src0_q.pop_front()});
        gnt_log.push_back(2'b01);
        acc = 1'b1;
      end else if (bus.req_valid_1 && bus.req_ready_1) begin
        exp_q.push_back({2'b10, src1_q.pop_front()});
        gnt_log.push_back(2'b10);
        acc = 1'b1;
      end else begin
        gnt_log.push_back(2'b00);
      end
      step();
      check("run_valid", phy_valid, acc);
      check("run_active", phy_active, 1'b1);
      if (acc) begin
        e = exp_q.pop_front();
        check("run_data", phy_data, e[31:0]);
        check("run_grant", grant, e[33:32]);
      end else begin
        check("fill_data", phy_data, IDLE_W);
        check("fill_grant", grant, 2'b00);
      end
    end
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b1;
    link_en         = 1'b0;
    bus.req_valid_0 = 1'b0;
    bus.req_valid_1 = 1'b0;
    bus.req_data_0  = 32'h0;
    bus.req_data_1  = 32'h0;
    #1;
    check_outputs_clear("rst_hold");
    repeat (2) @(posedge clk_2f);
    #1;
    reset = 1'b0;
    step();
    check_outputs_clear("post_rst");
    check("post_rst_ready0", bus.req_ready_0, 1'b0);

    // link_en / valid0, ready before edge, then outputs after edge
    add_vec(0, 1, 0, 0, 0, 32'h0,  0);
    add_vec(0, 0, 0, 0, 0, 32'h0,  0);
    add_vec(1, 1, 0, 0, 0, 32'h0,  0);
    add_vec(1, 1, 0, 1, 0, IDLE_W, 0);
    add_vec(1, 1, 0, 1, 0, IDLE_W, 0);
    add_vec(1, 1, 0, 1, 0, IDLE_W, 0);
    add_vec(1, 1, 0, 1, 0, IDLE_W, 0);
    add_vec(1, 0, 0, 1, 0, IDLE_W, 1);
    add_vec(1, 0, 0, 1, 0, IDLE_W, 1);
    add_vec(1, 0, 0, 1, 0, IDLE_W, 1);
    for (int i = 0; i < tv.size(); i++) begin
      link_en         = tv[i].link_en;
      bus.req_valid_0 = tv[i].v0;
      bus.req_data_0  = 32'hDEAD0000 | i;
      #2;
      check("tv_ready0", bus.req_ready_0, tv[i].exp_ready);
      step();
      check("tv_active", phy_active, tv[i].exp_active);
      check("tv_valid", phy_valid, tv[i].exp_valid);
      check("tv_data", phy_data, tv[i].exp_data);
      check("tv_link_up", link_up, tv[i].exp_link_up);
      check("tv_grant", grant, 2'b00);
    end
    bus.req_valid_0 = 1'b0;

    // Both sources saturated: 4 x src0, 4 x src1, 4 x src0
    gnt_log.delete();
    for (int i = 0; i < 8; i++) src0_q.push_back(32'hA0000000 + i);
    for (int i = 0; i < 4; i++) src1_q.push_back(32'hB1000000 + i);
    run(12);
    for (int i = 0; i < 12; i++)
      check("rr_pattern", gnt_log[i], (((i / 4) % 2) == 0) ? 2'b01 : 2'b10);
    check("rr_drained", src0_q.size() + src1_q.size(), 0);

    // Source 0 alone past the burst limit keeps streaming back-to-back
    gnt_log.delete();
    src0_q.push_back(32'hADFEBA01);
    src0_q.push_back(32'hFAFAFA01);
    src0_q.push_back(32'hAAAA1234);
    src0_q.push_back(32'h12345678);
    src0_q.push_back(32'h0BADF00D);
    src0_q.push_back(32'h600DCAFE);
    run(6);
    for (int i = 0; i < 6; i++) check("solo_grant", gnt_log[i], 2'b01);
    check("solo_drained", src0_q.size(), 0);

    // No requests while active: idle fill
    run(3);

    // Link drop on the 2nd word of a src1 burst
    src1_q.push_back(32'hC0DE0001);
    src1_q.push_back(32'hC0DE0002);
    src1_q.push_back(32'hC0DE0003);
    run(1);
    link_en         = 1'b0;
    bus.req_valid_1 = 1'b1;
    bus.req_data_1  = src1_q[0];
    #2;
    check("drop_ready1", bus.req_ready_1, 1'b0);
    check("drop_ready0", bus.req_ready_0, 1'b0);
    step();
    check("drop_active", phy_active, 1'b0);
    check("drop_valid", phy_valid, 1'b0);
    check("drop_link_up", link_up, 1'b0);
    for (int i = 0; i < 5; i++) begin
      link_en = 1'b1;
      #2;
      check("retrain_ready1", bus.req_ready_1, 1'b0);
      step();
      check("retrain_active", phy_active, (i == 0) ? 1'b0 : 1'b1);
      check("retrain_valid", phy_valid, 1'b0);
      check("retrain_link_up", link_up, 1'b0);
    end
    run(2);
    check("retrain_drained", src1_q.size(), 0);
    check("retrain_link_up_after", link_up, 1'b1);

    // Asynchronous reset mid-burst
    for (int i = 0; i < 4; i++) src0_q.push_back(32'hE0000000 + i);
    run(2);
    bus.req_valid_0 = 1'b1;
    bus.req_data_0  = src0_q[0];
    #2;
    reset = 1'b1;
    #1;
    check_outputs_clear("async_rst");
    check("async_rst_ready0", bus.req_ready_0, 1'b0);
    src0_q.delete();
    bus.req_valid_0 = 1'b0;
    link_en = 1'b0;
    step();
    reset = 1'b0;
    step();
    step();
    check("rel_active", phy_active, 1'b0);
    link_en = 1'b1;
    step();
    check("rel_active_n", phy_active, 1'b0);
    step();
    check("rel_active_n1", phy_active, 1'b1);
    check("rel_data_n1", phy_data, IDLE_W);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
